// File: rtl/issue_queue_if.sv
// Dispatch, commit-broadcast and issue buses of the operand wait queue.
// The slave side is the queue itself; the master side is whoever drives
// rename/dispatch, commit and the execution unit.
interface issue_queue_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 4,
    parameter int TAGW  = 3,
    parameter int OPW   = 8
);
    localparam int CW = $clog2(SIZE) + 1;

    // dispatch side
    logic             dsp_valid;
    logic             full;
    logic [CW-1:0]    count;
    logic [OPW-1:0]   dsp_op;
    logic [TAGW-1:0]  dsp_tag;
    logic [1:0]       dsp_wait;
    logic [TAGW-1:0]  dsp_tl;
    logic [TAGW-1:0]  dsp_tr;
    logic [WIDTH-1:0] dsp_a;
    logic [WIDTH-1:0] dsp_b;
    logic [WIDTH-1:0] dsp_imm;

    // commit broadcast
    logic [4:0]       cm_rno;
    logic [2:0]       cm_exc;
    logic [WIDTH-1:0] cm_rval;
    logic [TAGW-1:0]  cm_rbus;

    // issue side
    logic             iss_valid;
    logic             iss_ready;
    logic [OPW-1:0]   iss_op;
    logic [TAGW-1:0]  iss_tag;
    logic [WIDTH-1:0] iss_a;
    logic [WIDTH-1:0] iss_b;
    logic [WIDTH-1:0] iss_imm;

    modport slave (
        input  dsp_valid, dsp_op, dsp_tag, dsp_wait, dsp_tl, dsp_tr,
               dsp_a, dsp_b, dsp_imm,
        input  cm_rno, cm_exc, cm_rval, cm_rbus,
        input  iss_ready,
        output full, count,
        output iss_valid, iss_op, iss_tag, iss_a, iss_b, iss_imm
    );

    modport master (
        output dsp_valid, dsp_op, dsp_tag, dsp_wait, dsp_tl, dsp_tr,
               dsp_a, dsp_b, dsp_imm,
        output cm_rno, cm_exc, cm_rval, cm_rbus,
        output iss_ready,
        input  full, count,
        input  iss_valid, iss_op, iss_tag, iss_a, iss_b, iss_imm
    );
endinterface

// File: rtl/issue_queue.sv
// Operand wait queue between dispatch and the single execution unit.
// Entries are allocated in order into a compacting array (slot 0 oldest),
// capture operand values from the commit broadcast, and the oldest entry
// with both operands present is moved into a registered valid/ready stage.
module issue_queue #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 4,
    parameter int TAGW  = 3,
    parameter int OPW   = 8
) (
    input logic         clk,
    input logic         rst,
    issue_queue_if.slave bus
);
    localparam int IW = $clog2(SIZE);
    localparam int CW = IW + 1;
    localparam logic [4:0] R_ZERO   = 5'd0;
    localparam logic [2:0] EXC_NONE = 3'd0;

    typedef struct packed {
        logic             v;
        logic [OPW-1:0]   op;
        logic [TAGW-1:0]  tag;
        logic             wl;
        logic             wr;
        logic [TAGW-1:0]  tl;
        logic [TAGW-1:0]  tr;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] imm;
    } ent_t;

    ent_t          ent [SIZE];
    ent_t          wk  [SIZE];
    ent_t          nxt [SIZE];
    ent_t          din;
    logic [CW-1:0] cnt;
    logic          wake_hit, flush, any_rdy, load, removed, accept;
    logic [IW-1:0] sel;
    logic [CW-1:0] widx;

    // output stage registers
    logic             vld_p1;
    logic [OPW-1:0]   op_p1;
    logic [TAGW-1:0]  tag_p1;
    logic [WIDTH-1:0] a_p1, b_p1, imm_p1;

    assign bus.count     = cnt;
    assign bus.full      = (cnt == CW'(SIZE));
    assign bus.iss_valid = vld_p1;
    assign bus.iss_op    = op_p1;
    assign bus.iss_tag   = tag_p1;
    assign bus.iss_a     = a_p1;
    assign bus.iss_b     = b_p1;
    assign bus.iss_imm   = imm_p1;

    // Decode the commit broadcast and the per-edge handshake decisions
    always_comb begin
        wake_hit = (bus.cm_rno != R_ZERO) && (bus.cm_exc == EXC_NONE);
        flush    = (bus.cm_exc != EXC_NONE);
        load     = !vld_p1 || bus.iss_ready;
        removed  = load && any_rdy && !flush;
        accept   = bus.dsp_valid && !bus.full && !flush;
        widx     = cnt - CW'(removed);
    end

    // Pick the lowest-index entry whose operands are both present (registered state only)
    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (ent[i].v && !ent[i].wl && !ent[i].wr) begin
                any_rdy = 1'b1;
                sel     = IW'(i);
            end
        end
    end

    // Build the incoming entry, bypassing a broadcast that lands in the same cycle
    always_comb begin
        din     = '0;
        din.v   = 1'b1;
        din.op  = bus.dsp_op;
        din.tag = bus.dsp_tag;
        din.tl  = bus.dsp_tl;
        din.tr  = bus.dsp_tr;
        din.imm = bus.dsp_imm;
        din.wl  = bus.dsp_wait[1];
        din.wr  = bus.dsp_wait[0];
        din.a   = bus.dsp_a;
        din.b   = bus.dsp_b;
        if (bus.dsp_wait[1] && wake_hit && bus.dsp_tl == bus.cm_rbus) begin
            din.a  = bus.cm_rval;
            din.wl = 1'b0;
        end
        if (bus.dsp_wait[0] && wake_hit && bus.dsp_tr == bus.cm_rbus) begin
            din.b  = bus.cm_rval;
            din.wr = 1'b0;
        end
    end

    // Next array contents: wake, then compact over the removed slot, then append
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            wk[i] = ent[i];
            if (wake_hit && ent[i].v && ent[i].wl && ent[i].tl == bus.cm_rbus) begin
                wk[i].a  = bus.cm_rval;
                wk[i].wl = 1'b0;
            end
            if (wake_hit && ent[i].v && ent[i].wr && ent[i].tr == bus.cm_rbus) begin
                wk[i].b  = bus.cm_rval;
                wk[i].wr = 1'b0;
            end
        end
        for (int i = 0; i < SIZE - 1; i++) begin
            nxt[i] = (removed && IW'(i) >= sel) ? wk[i+1] : wk[i];
        end
        nxt[SIZE-1] = wk[SIZE-1];
        if (removed) begin
            nxt[SIZE-1].v = 1'b0;
        end
        for (int i = 0; i < SIZE; i++) begin
            if (accept && widx == CW'(i)) begin
                nxt[i] = din;
            end
            if (flush) begin
                nxt[i].v = 1'b0;
            end
        end
    end

    // Entry storage; only the valid bits are cleared by reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (rst) begin
                ent[i].v <= 1'b0;
            end else begin
                ent[i] <= nxt[i];
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(accept) - CW'(removed);
        end
    end

    // Output stage valid: reloads whenever empty or accepted downstream
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= any_rdy;
        end
    end

    // Output stage payload: held while stalled, copied from the selected entry on load
    always_ff @(posedge clk) begin
        if (rst) begin
            op_p1  <= '0;
            tag_p1 <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            imm_p1 <= '0;
        end else if (removed) begin
            op_p1  <= ent[sel].op;
            tag_p1 <= ent[sel].tag;
            a_p1   <= ent[sel].a;
            b_p1   <= ent[sel].b;
            imm_p1 <= ent[sel].imm;
        end
    end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- In-order-allocated, out-of-order-issue operand wait queue placed between rename/dispatch and the single execution unit.
- Receives decoded ops with operand values or the ROB tags they wait on, taken from the commit stage register map query (rob_wait/rob_rl/rob_rr/rob_next).
- Snoops the commit broadcast to capture waiting operand values and flushes on an excepting commit.
- Issues the oldest fully-ready entry through a registered valid/ready output stage.

Parameters:
- WIDTH, 32, data/pc width.
- SIZE, 4, number of queue entries (power of two, >= 2).
- TAGW, 3, ROB tag width; must equal $clog2 of the ROB SIZE.
- OPW, 8, opcode field width carried through untouched.

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- dsp_valid  in  1  dispatch request
- full  out  1  count == SIZE; dispatch ignored while high
- count  out  $clog2(SIZE)+1  occupied entries
- dsp_op  in  OPW  opcode
- dsp_tag  in  TAGW  ROB slot of this op (rob_next)
- dsp_wait  in  2  bit1 = left operand waiting, bit0 = right (rob_wait order)
- dsp_tl / dsp_tr  in  TAGW  producer ROB tags (rob_rl / rob_rr)
- dsp_a / dsp_b  in  WIDTH  register file values, used when not waiting
- dsp_imm  in  WIDTH  immediate
- cm_rno  in  5  commit register number (R_ZERO = no register commit)
- cm_exc  in  3  commit exception code (EXC_NONE = 0)
- cm_rval  in  WIDTH  commit value
- cm_rbus  in  TAGW  committed ROB tag
- iss_valid  out  1  issue output valid
- iss_ready  in  1  execution unit accepts
- iss_op / iss_tag / iss_a / iss_b / iss_imm  out  OPW / TAGW / WIDTH / WIDTH / WIDTH  issued op fields

Behaviour:
- Reset: all entries invalid; count = 0; full = 0; iss_valid = 0; iss_* data = 0.
- Priority at each edge: rst > flush > (wake, issue, dispatch).
- Wake hit: cm_rno != R_ZERO and cm_exc == EXC_NONE.
- Flush: cm_exc != EXC_NONE.
  - Next edge: all entries invalid, count = 0, iss_valid = 0.
  - A same-cycle dispatch is dropped.
  - Flush overrides any pending handshake; iss_ready is ignored that cycle.
- Storage: compacting array; slot 0 is the oldest. Entry = {valid, op, tag, wl, wr, tl, tr, a, b, imm}.
- Dispatch accepted when dsp_valid & !full.
  - Writes slot (count - removed), where removed = 1 if an entry leaves at the same edge, else 0.
  - A dispatched operand waiting on a tag that wake-hits the same cycle stores cm_rval with its wait bit clear (dispatch bypass).
- Wake, each valid entry:
  - if wl & tl == cm_rbus on a wake hit: a <= cm_rval, wl <= 0. Same rule for wr/tr/b.
  - Both operands may wake from one broadcast.
- Ready = valid & !wl & !wr, using registered state only.
  - An entry written or woken at edge E is first eligible in the cycle after E.
  - Dispatch with no waits at edge E0 -> iss_valid high after E1 at the earliest.
- Output stage loads when !iss_valid | iss_ready:
  - if any entry is ready, the lowest-index ready entry is copied to iss_*, iss_valid <= 1, and the entry is removed (younger slots shift down one).
  - Otherwise iss_valid <= 0.
  - While iss_valid & !iss_ready, iss_* are held stable.
- Count arithmetic: count_next = count + accepted - removed. Simultaneous dispatch and removal when full is legal only for removal; full blocks dispatch on the registered count.
- Tag aliasing: a broadcast matching a slot is the unique live producer; no age check needed.
- Entries carry no pc or exception state.

Test Plan:
- Reset, then dispatch op 0x11, tag 2, no waits, a = 5, b = 7, iss_ready = 1 -> iss_valid after 2 edges with iss_a = 5, iss_b = 7, iss_tag = 2; count back to 0.
- Dispatch tag 3 with wl, tl = 1. Broadcast cm_rno = 4, cm_rbus = 1, cm_rval = 0xCAFE -> issue one edge later with iss_a = 0xCAFE. The same tag with cm_rno = 0 must not wake.
- Dispatch with wr, tr = 5 in the same cycle as a broadcast with cm_rbus = 5, cm_rval = 9 -> entry is immediately ready; iss_b = 9.
- Fill 4 entries with iss_ready = 0 -> full = 1 and a 5th dispatch is ignored. Raise iss_ready -> ops issue in slot order; only ready entries are chosen; an older waiting entry is bypassed by a younger ready one.
- With 3 queued entries and iss_valid held, broadcast cm_exc = 2 -> next edge count = 0, iss_valid = 0, the concurrent dispatch is lost.
- Assert rst while full and stalled -> count = 0, full = 0, iss_valid = 0. A dispatch the cycle after rst deasserts is accepted.
